vga_timing_gen: RTL and testbench

//  Parametrised combined horizontal + vertical raster timing generator for the VGA path.

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: two front-porch/sync/back-porch/video FSMs (pixels, lines)
// decoded into sync, data-valid, active coordinates and line/frame start strobes.
module vga_timing_gen #(
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned V_ACTIVE = 480,
   parameter bit          SYNC_POL = 1'b0,
   parameter int unsigned CNT_W    = 12
) (
   input  logic             pixelClk,
   input  logic             rst,
   input  logic             pixelEn,
   output logic             hsync,
   output logic             vsync,
   output logic             dataValid,
   output logic [CNT_W-1:0] pixelX,
   output logic [CNT_W-1:0] pixelY,
   output logic             lineStart,
   output logic             frameStart
);

   typedef enum logic [1:0] {
      FRONT_PORCH = 2'd0,
      SYNC        = 2'd1,
      BACK_PORCH  = 2'd2,
      VIDEO       = 2'd3
   } phase_t;

   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   // Every interval must be non-empty and representable in the counters.
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || H_ACTIVE < 1 ||
       V_FP < 1 || V_SYNC < 1 || V_BP < 1 || V_ACTIVE < 1) begin : g_bad_len
      $error("vga_timing_gen: every porch/sync/active length must be >= 1");
   end
   if (longint'(H_FP) > CNT_MAX || longint'(H_SYNC) > CNT_MAX || longint'(H_BP) > CNT_MAX ||
       longint'(H_ACTIVE) > CNT_MAX || longint'(V_FP) > CNT_MAX || longint'(V_SYNC) > CNT_MAX ||
       longint'(V_BP) > CNT_MAX || longint'(V_ACTIVE) > CNT_MAX) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too narrow for the timing parameters");
   end

   function automatic phase_t next_phase(input phase_t s);
      case (s)
         FRONT_PORCH: next_phase = SYNC;
         SYNC:        next_phase = BACK_PORCH;
         BACK_PORCH:  next_phase = VIDEO;
         VIDEO:       next_phase = FRONT_PORCH;
         default:     next_phase = FRONT_PORCH;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] h_last(input phase_t s);
      case (s)
         FRONT_PORCH: h_last = CNT_W'(H_FP - 1);
         SYNC:        h_last = CNT_W'(H_SYNC - 1);
         BACK_PORCH:  h_last = CNT_W'(H_BP - 1);
         VIDEO:       h_last = CNT_W'(H_ACTIVE - 1);
         default:     h_last = '0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] v_last(input phase_t s);
      case (s)
         FRONT_PORCH: v_last = CNT_W'(V_FP - 1);
         SYNC:        v_last = CNT_W'(V_SYNC - 1);
         BACK_PORCH:  v_last = CNT_W'(V_BP - 1);
         VIDEO:       v_last = CNT_W'(V_ACTIVE - 1);
         default:     v_last = '0;
      endcase
   endfunction

   phase_t           r_hState;
   phase_t           r_vState;
   logic [CNT_W-1:0] r_hCnt;
   logic [CNT_W-1:0] r_vCnt;

   logic             w_hEnd;
   logic             w_vStep;
   logic             w_vEnd;
   logic             w_dv;
   logic             w_lineStart;

   always_comb begin
      w_hEnd  = (r_hCnt == h_last(r_hState));
      // Lines advance only on the pixel that leaves horizontal video.
      w_vStep = pixelEn && w_hEnd && (r_hState == VIDEO);
      w_vEnd  = (r_vCnt == v_last(r_vState));
   end

   always_ff @(posedge pixelClk) begin
      if (!rst) begin
         r_hState <= FRONT_PORCH;
         r_hCnt   <= '0;
      end else if (pixelEn) begin
         if (w_hEnd) begin
            r_hCnt   <= '0;
            r_hState <= next_phase(r_hState);
         end else begin
            r_hCnt   <= r_hCnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge pixelClk) begin
      if (!rst) begin
         r_vState <= FRONT_PORCH;
         r_vCnt   <= '0;
      end else if (w_vStep) begin
         if (w_vEnd) begin
            r_vCnt   <= '0;
            r_vState <= next_phase(r_vState);
         end else begin
            r_vCnt   <= r_vCnt + CNT_W'(1);
         end
      end
   end

   // Outputs are pure decodes of the state registers, so they hold with the state.
   assign w_dv        = (r_hState == VIDEO) && (r_vState == VIDEO);
   assign w_lineStart = w_dv && (r_hCnt == '0) && pixelEn;

   assign hsync      = (r_hState == SYNC) ? SYNC_POL : ~SYNC_POL;
   assign vsync      = (r_vState == SYNC) ? SYNC_POL : ~SYNC_POL;
   assign dataValid  = w_dv;
   assign pixelX     = w_dv ? r_hCnt : '0;
   assign pixelY     = w_dv ? r_vCnt : '0;
   assign lineStart  = w_lineStart;
   assign frameStart = w_lineStart && (r_vCnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance plus a tiny active-high-sync instance sharing
// clock, reset and enable; expected cycle positions are worked out by hand from the timing.
module tb_vga_timing_gen;

   logic        pixelClk = 1'b0;
   logic        rst      = 1'b0;
   logic        pixelEn  = 1'b1;

   logic        d_hs, d_vs, d_dv, d_ls, d_fs;
   logic [11:0] d_x, d_y;
   logic        s_hs, s_vs, s_dv, s_ls, s_fs;
   logic [3:0]  s_x, s_y;

   int n_chk = 0;
   int n_err = 0;

   always #5 pixelClk = ~pixelClk;

   vga_timing_gen u_dut (
      .pixelClk  (pixelClk),
      .rst       (rst),
      .pixelEn   (pixelEn),
      .hsync     (d_hs),
      .vsync     (d_vs),
      .dataValid (d_dv),
      .pixelX    (d_x),
      .pixelY    (d_y),
      .lineStart (d_ls),
      .frameStart(d_fs)
   );

   // 12-pixel lines, 7-line frames (84 cycles), active-high syncs.
   vga_timing_gen #(
      .H_FP(2), .H_SYNC(3), .H_BP(2), .H_ACTIVE(5),
      .V_FP(1), .V_SYNC(2), .V_BP(1), .V_ACTIVE(3),
      .SYNC_POL(1'b1), .CNT_W(4)
   ) u_small (
      .pixelClk  (pixelClk),
      .rst       (rst),
      .pixelEn   (pixelEn),
      .hsync     (s_hs),
      .vsync     (s_vs),
      .dataValid (s_dv),
      .pixelX    (s_x),
      .pixelY    (s_y),
      .lineStart (s_ls),
      .frameStart(s_fs)
   );

   int d_hfall1, d_hfall2, d_hrise1, d_hlow;
   int d_vfall1, d_vlast, d_vlow;
   int d_fs1, d_fscnt, d_fsx, d_fsy, d_lscnt;
   int d_dvcnt, d_dvrun, d_dvrunmax;
   int s_hhigh, s_vhigh, s_dv84, s_fs1, s_fs2, s_fscnt, s_lscnt;
   int hold_err, strobe_err;
   logic [3:0]  s83_x, s83_y, s84_x, s84_y;
   logic        s83_dv, s84_dv, s84_vs;
   logic        d_prev_hs;
   logic [37:0] prev_vec;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, " d_hsync"}, d_hs, 1);
      check_val({tag, " d_vsync"}, d_vs, 1);
      check_val({tag, " d_dv"},    d_dv, 0);
      check_val({tag, " d_x"},     d_x,  0);
      check_val({tag, " d_y"},     d_y,  0);
      check_val({tag, " d_strb"},  {d_ls, d_fs}, 0);
      check_val({tag, " s_hsync"}, s_hs, 0);
      check_val({tag, " s_vsync"}, s_vs, 0);
      check_val({tag, " s_dv"},    s_dv, 0);
      check_val({tag, " s_xy"},    {s_x, s_y}, 0);
      check_val({tag, " s_strb"},  {s_ls, s_fs}, 0);
   endtask

   // Window c starts 1 time unit after the c-th clock edge following reset release.
   task automatic run(input int n, input bit toggle);
      d_hfall1 = -1; d_hfall2 = -1; d_hrise1 = -1; d_hlow = 0;
      d_vfall1 = -1; d_vlast = -1; d_vlow = 0;
      d_fs1 = -1; d_fscnt = 0; d_fsx = -1; d_fsy = -1; d_lscnt = 0;
      d_dvcnt = 0; d_dvrun = 0; d_dvrunmax = 0;
      s_hhigh = 0; s_vhigh = 0; s_dv84 = 0; s_fs1 = -1; s_fs2 = -1; s_fscnt = 0; s_lscnt = 0;
      hold_err = 0; strobe_err = 0;
      d_prev_hs = 1'b1;
      prev_vec = '0;
      for (int c = 0; c < n; c++) begin
         pixelEn = toggle ? (c % 2 == 0) : 1'b1;
         #1;
         if (d_prev_hs && !d_hs) begin
            if (d_hfall1 < 0) d_hfall1 = c;
            else if (d_hfall2 < 0) d_hfall2 = c;
         end
         if (!d_prev_hs && d_hs && d_hrise1 < 0) d_hrise1 = c;
         if (c < 1600 && !d_hs) d_hlow++;
         if (!d_vs) begin
            if (d_vfall1 < 0) d_vfall1 = c;
            d_vlast = c;
            d_vlow++;
         end
         if (d_fs) begin
            d_fscnt++;
            if (d_fs1 < 0) begin
               d_fs1 = c; d_fsx = int'(d_x); d_fsy = int'(d_y);
            end
         end
         if (d_ls) d_lscnt++;
         if (d_dv) begin
            d_dvcnt++;
            d_dvrun++;
            if (d_dvrun > d_dvrunmax) d_dvrunmax = d_dvrun;
         end else begin
            d_dvrun = 0;
         end
         if (c < 84) begin
            if (s_hs) s_hhigh++;
            if (s_vs) s_vhigh++;
            if (s_dv) s_dv84++;
         end
         if (s_fs) begin
            s_fscnt++;
            if (s_fs1 < 0) s_fs1 = c;
            else if (s_fs2 < 0) s_fs2 = c;
         end
         if (s_ls) s_lscnt++;
         if (c == 83) begin
            s83_x = s_x; s83_y = s_y; s83_dv = s_dv;
         end
         if (c == 84) begin
            s84_x = s_x; s84_y = s_y; s84_dv = s_dv; s84_vs = s_vs;
         end
         if (toggle) begin
            if (!pixelEn && (d_ls || d_fs || s_ls || s_fs)) strobe_err++;
            if (pixelEn && c > 0 &&
                ({d_hs, d_vs, d_dv, d_x, d_y, s_hs, s_vs, s_dv, s_x, s_y} != prev_vec))
               hold_err++;
         end
         prev_vec  = {d_hs, d_vs, d_dv, d_x, d_y, s_hs, s_vs, s_dv, s_x, s_y};
         d_prev_hs = d_hs;
         if (c != n - 1) begin
            @(posedge pixelClk);
            #1;
         end
      end
   endtask

   initial begin
      rst     = 1'b0;
      pixelEn = 1'b1;
      repeat (5) @(posedge pixelClk);
      #1;
      check_reset("rst0");

      // Free run past the first frame start and into line 46, then reset at X=300, Y=1.
      rst = 1'b1;
      run(37261, 1'b0);
      check_val("hsync_fall",   d_hfall1, 16);
      check_val("hsync_rise",   d_hrise1, 112);
      check_val("hsync_period", d_hfall2 - d_hfall1, 800);
      check_val("hsync_low_2l", d_hlow, 192);
      check_val("vsync_fall",   d_vfall1, 8000);
      check_val("vsync_last",   d_vlast, 9599);
      check_val("vsync_low",    d_vlow, 1600);
      check_val("fs_cycle",     d_fs1, 36160);
      check_val("fs_x",         d_fsx, 0);
      check_val("fs_y",         d_fsy, 0);
      check_val("fs_count",     d_fscnt, 1);
      check_val("ls_count",     d_lscnt, 2);
      check_val("dv_count",     d_dvcnt, 941);
      check_val("dv_run",       d_dvrunmax, 640);
      check_val("mid_x",        d_x, 300);
      check_val("mid_y",        d_y, 1);
      check_val("mid_dv",       d_dv, 1);
      check_val("s_hs_high",    s_hhigh, 21);
      check_val("s_vs_high",    s_vhigh, 24);
      check_val("s_dv_frame",   s_dv84, 15);
      check_val("s_fs_first",   s_fs1, 55);
      check_val("s_fs_period",  s_fs2 - s_fs1, 84);
      check_val("s_fs_count",   s_fscnt, 443);
      check_val("s_ls_count",   s_lscnt, 1329);
      check_val("s_last_x",     s83_x, 4);
      check_val("s_last_y",     s83_y, 2);
      check_val("s_last_dv",    s83_dv, 1);
      check_val("s_after_dv",   s84_dv, 0);
      check_val("s_after_vs",   s84_vs, 0);
      check_val("s_after_xy",   {s84_x, s84_y}, 0);

      rst = 1'b0;
      @(posedge pixelClk);
      #1;
      check_reset("rst_mid");
      rst = 1'b1;
      run(200, 1'b0);
      check_val("re_hsync_fall", d_hfall1, 16);
      check_val("re_hsync_rise", d_hrise1, 112);
      check_val("re_vsync_low",  d_vlow, 0);
      check_val("re_dv_count",   d_dvcnt, 0);
      check_val("re_s_fs_first", s_fs1, 55);

      // Enable toggling 1/0: every interval doubles.
      rst = 1'b0;
      @(posedge pixelClk);
      #1;
      check_reset("rst_tog");
      rst = 1'b1;
      run(400, 1'b1);
      check_val("tog_hsync_fall", d_hfall1, 31);
      check_val("tog_hsync_rise", d_hrise1, 223);
      check_val("tog_s_fs_first", s_fs1, 110);
      check_val("tog_s_fs_2nd",   s_fs2, 278);
      check_val("tog_s_fs_count", s_fscnt, 2);
      check_val("tog_s_ls_count", s_lscnt, 6);
      check_val("tog_hold",       hold_err, 0);
      check_val("tog_strobe",     strobe_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
